// File: rtl/mux16_rr_arbiter.sv
// mux16_rr_arbiter
// Round-robin arbiter and sequencer for a shared 16:1 W-bit datapath mux.
// It grants one requester at a time and drives the mux select lines.
// Each tenure is bounded to HOLD_MAX cycles. A released or timed-out tenure
// hands over to the next requester in rotation with no idle bubble.
// Optional feature macro: MUX16_ARB_LOCK_EN adds a 'lock' input. While lock
// is high, it suppresses the timeout of the current tenure.
module mux16_rr_arbiter #(
  parameter int W        = 32,
  parameter int HOLD_MAX = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] req,
`ifdef MUX16_ARB_LOCK_EN
  input  logic        lock,
`endif
  output logic [15:0] gnt,
  output logic [3:0]  sel,
  output logic        busy,
  output logic [7:0]  hold_cnt
);

  // W sizes the controlled mux only. HOLD_MAX must fit the 8-bit tenure counter.
  if (W < 1 || HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_cfg_err
    $error("mux16_rr_arbiter: illegal W or HOLD_MAX");
  end

  localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t      state, state_n;
  logic [3:0]  ptr, ptr_n, sel_n;
  logic [7:0]  hold_n;
  logic [15:0] gnt_n;
  logic        busy_n;
  logic [3:0]  win;
  logic        lock_act;
  logic        tenure_end;

  // Tenure counter saturates instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // First requester in the order p+1, p+2, ..., p+16 (mod 16).
  // Scanning from the far end means the nearest hit is written last and wins.
  function automatic logic [3:0] rr_pick(input logic [15:0] r, input logic [3:0] p);
    logic [3:0] idx;
    logic [3:0] best;
    best = p;
    for (int i = 16; i >= 1; i--) begin
      idx = p + 4'(i);
      if (r[idx]) best = idx;
    end
    return best;
  endfunction

`ifdef MUX16_ARB_LOCK_EN
  assign lock_act = lock;
`else
  assign lock_act = 1'b0;
`endif

  assign win = rr_pick(req, ptr);

  // Use ">=" so that a tenure stretched past the limit by lock ends as soon as lock drops.
  assign tenure_end = !req[sel] || ((hold_cnt >= HOLD_LIM) && !lock_act);

  // State register: all control and outputs are registered and clear asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= 4'hF;
      sel      <= 4'h0;
      hold_cnt <= 8'h00;
      gnt      <= 16'h0000;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      sel      <= sel_n;
      hold_cnt <= hold_n;
      gnt      <= gnt_n;
      busy     <= busy_n;
    end
  end

  // Next-state logic: start, continue, hand over or end a tenure.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    sel_n   = sel;
    hold_n  = hold_cnt;
    if (state == IDLE) begin
      if (|req) begin
        state_n = GRANT;
        sel_n   = win;
        ptr_n   = win;
        hold_n  = 8'd1;
      end
    end else begin
      if (tenure_end) begin
        if (|req) begin
          // ptr equals sel here, so the search starts at sel+1.
          sel_n  = win;
          ptr_n  = win;
          hold_n = 8'd1;
        end else begin
          state_n = IDLE;
          hold_n  = 8'd0;
        end
      end else begin
        hold_n = sat_inc(hold_cnt);
      end
    end
  end

  // Output decode of the next state; the result is registered alongside the state.
  always_comb begin
    gnt_n  = 16'h0000;
    busy_n = 1'b0;
    if (state_n == GRANT) begin
      gnt_n  = 16'd1 << sel_n;
      busy_n = 1'b1;
    end
  end

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Bench for mux16_rr_arbiter. It applies directed and randomized request
// patterns and compares the DUT against a behavioural round-robin model.
module tb_mux16_rr_arbiter;

  localparam int HM = 4;
`ifdef MUX16_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] req;
  logic        lock;
  logic [15:0] gnt;
  logic [3:0]  sel;
  logic        busy;
  logic [7:0]  hold_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit m_busy;
  int m_sel;
  int m_last;
  int m_cnt;

  always #5 clk = ~clk;

  mux16_rr_arbiter #(.W(32), .HOLD_MAX(HM)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
`ifdef MUX16_ARB_LOCK_EN
    .lock     (lock),
`endif
    .gnt      (gnt),
    .sel      (sel),
    .busy     (busy),
    .hold_cnt (hold_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // The winner has the smallest rotational distance after 'last'.
  // Requester last+1 is at distance 0, and 'last' itself is at distance 15.
  function automatic int pick(input logic [15:0] r, input int last);
    int best  = -1;
    int bestd = 16;
    for (int i = 0; i < 16; i++) begin
      if (r[i]) begin
        int d = (i - last + 15) % 16;
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  function automatic void model_reset();
    m_busy = 1'b0;
    m_sel  = 0;
    m_last = 15;
    m_cnt  = 0;
  endfunction

  function automatic void model_step(input logic [15:0] r, input logic lk);
    bit lk_eff = LOCK_EN && lk;
    bit fin;
    if (!m_busy) begin
      if (r != 16'h0) begin
        m_sel  = pick(r, m_last);
        m_last = m_sel;
        m_cnt  = 1;
        m_busy = 1'b1;
      end
    end else begin
      fin = !r[m_sel] || (m_cnt >= HM && !lk_eff);
      if (fin) begin
        if (r != 16'h0) begin
          m_sel  = pick(r, m_last);
          m_last = m_sel;
          m_cnt  = 1;
        end else begin
          m_busy = 1'b0;
        end
      end else begin
        m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
      end
    end
  endfunction

  task automatic compare_all();
    logic [15:0] eg;
    eg = m_busy ? (16'd1 << m_sel) : 16'h0;
    check("gnt", 32'(gnt), 32'(eg));
    check("sel", 32'(sel), 32'(m_sel));
    check("busy", 32'(busy), 32'(m_busy));
    check("onehot0", 32'($onehot0(gnt)), 32'd1);
    if (m_busy) check("hold_cnt", 32'(hold_cnt), 32'(m_cnt));
  endtask

  // One clock: drive inputs, advance model, check just after the edge.
  task automatic cycle(input logic [15:0] r, input logic lk);
    req  = r;
    lock = lk;
    model_step(r, lk);
    @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_gnt"}, 32'(gnt), 32'h0);
    check({tag, "_sel"}, 32'(sel), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_hold"}, 32'(hold_cnt), 32'h0);
  endtask

  logic [15:0] rq;
  logic [31:0] rnd;

  initial begin
    reset = 1'b1;
    req   = 16'h0;
    lock  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("por");
    @(negedge clk);
    reset = 1'b0;

    // Single requester 5 for three cycles, then release.
    repeat (3) cycle(16'h0020, 1'b0);
    cycle(16'h0000, 1'b0);
    cycle(16'h0000, 1'b0);

    // Full contention: each index gets HM cycles in turn with no idle gap.
    repeat (16 * HM + 2 * HM) cycle(16'hFFFF, 1'b0);
    cycle(16'h0000, 1'b0);

    // Fairness: leave ptr at 3, then 12 must win over 3.
    cycle(16'h0008, 1'b0);
    cycle(16'h0000, 1'b0);
    repeat (HM + 3) cycle(16'h1008, 1'b0);
    cycle(16'h0000, 1'b0);

    // Sole requester times out and is re-granted with the counter restarted.
    repeat (2 * HM + 2) cycle(16'h0004, 1'b0);
    cycle(16'h0000, 1'b0);

    // Lock holds the path past HOLD_MAX; the handover follows the lock release.
    if (LOCK_EN) begin
      repeat (6) cycle(16'h0101, 1'b1);
      repeat (3) cycle(16'h0101, 1'b0);
      cycle(16'h0000, 1'b0);
      // Counter saturation under a long lock
      repeat (262) cycle(16'h0001, 1'b1);
      cycle(16'h0001, 1'b0);
      cycle(16'h0000, 1'b1);
    end

    // Randomized traffic
    rq = 16'h0;
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        rnd = $urandom;
        case ($urandom_range(0, 3))
          0: rq = 16'h0;
          1: rq = 16'd1 << $urandom_range(0, 15);
          2: rq = rnd[15:0] & rnd[31:16];
          default: rq = rnd[15:0];
        endcase
      end
      cycle(rq, LOCK_EN ? ($urandom_range(0, 3) == 0) : 1'b0);
    end

    // Asynchronous reset in mid-grant: outputs clear without a clock edge.
    repeat (HM + 3) cycle(16'hFFFF, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals("async");
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    // Post-reset order restarts at requester 0.
    repeat (3 * HM + 1) cycle(16'hFFFF, 1'b0);
    cycle(16'h0000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
